// File: rtl/fp_mult_result_pack_if.sv
// Handshake/datapath bundle between the multiplier pipeline, the result packer and the FPU output.
// EW/SW follow W: 32 -> single precision, 64 -> double precision.
interface fp_mult_result_pack_if #(parameter int W = 32);
  localparam int EW = (W == 64) ? 11 : 8;
  localparam int SW = W - EW - 1;

  logic          in_valid;
  logic          in_ready;
  logic          zero_m_flag;
  logic          sign_a;
  logic          sign_b;
  logic [EW+1:0] exp_biased;
  logic [SW-1:0] mant_norm;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          overflow_flag;
  logic          underflow_flag;

  modport slave (
    input  in_valid, zero_m_flag, sign_a, sign_b, exp_biased, mant_norm, out_ready,
    output in_ready, out_valid, result, overflow_flag, underflow_flag
  );

  modport master (
    output in_valid, zero_m_flag, sign_a, sign_b, exp_biased, mant_norm, out_ready,
    input  in_ready, out_valid, result, overflow_flag, underflow_flag
  );
endinterface

// File: rtl/fp_mult_result_pack.sv
// Final multiplier stage: classify zero/overflow/underflow/normal and pack the IEEE-754 product.
// Three-state handshake (IDLE -> EVAL -> DONE), so at most one result every three cycles.
module fp_mult_result_pack #(
  parameter int W = 32
) (
  input logic                clk,
  input logic                rst,
  fp_mult_result_pack_if.slave bus
);
  localparam int EW = (W == 64) ? 11 : 8;
  localparam int SW = W - EW - 1;

  localparam logic signed [EW+1:0] EXP_INF  = {2'b00, {EW{1'b1}}};
  localparam logic signed [EW+1:0] EXP_ZERO = '0;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t        state_q, state_d;
  logic          accept;
  logic          zero_q, sign_q;
  logic [EW+1:0] exp_q;
  logic [SW-1:0] mant_q;
  logic [W-1:0]  result_q, result_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        accept  = 1'b1;
        state_d = EVAL;
      end
      EVAL:    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Zero operand wins over any exponent; exponent checks are signed, so a
  // negative (wrapped) sum flushes to zero instead of aliasing a large exponent.
  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (zero_q) begin
      result_d = {sign_q, {(W-1){1'b0}}};
    end else if ($signed(exp_q) >= EXP_INF) begin
      result_d = {sign_q, {EW{1'b1}}, {SW{1'b0}}};
      ovf_d    = 1'b1;
    end else if ($signed(exp_q) <= EXP_ZERO) begin
      result_d = {sign_q, {(W-1){1'b0}}};
      unf_d    = 1'b1;
    end else begin
      result_d = {sign_q, exp_q[EW-1:0], mant_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        zero_q <= bus.zero_m_flag;
        sign_q <= bus.sign_a ^ bus.sign_b;
        exp_q  <= bus.exp_biased;
        mant_q <= bus.mant_norm;
      end
      if (state_q == EVAL) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
      end
    end
  end

  assign bus.in_ready       = (state_q == IDLE);
  assign bus.out_valid      = (state_q == DONE);
  assign bus.result         = result_q;
  assign bus.overflow_flag  = ovf_q;
  assign bus.underflow_flag = unf_q;
endmodule
